// File: rtl/map_pkg.sv
// Shared constants and types for the map-transform op sequencer.
package map_pkg;

    localparam int unsigned MAP_DIM   = 8;
    localparam int unsigned ADDR_W    = 6;
    localparam int unsigned OP_NUM    = 15;
    localparam int unsigned NUM_BEATS = MAP_DIM * MAP_DIM;
    localparam int unsigned RD_NUM    = 16;

    // Op codes as captured from the input port
    localparam logic [3:0] OP_MID     = 4'd0;
    localparam logic [3:0] OP_AVG     = 4'd1;
    localparam logic [3:0] OP_ROT_CCW = 4'd2;
    localparam logic [3:0] OP_ROT_CW  = 4'd3;
    localparam logic [3:0] OP_FLIP    = 4'd4;
    localparam logic [3:0] OP_UP      = 4'd5;
    localparam logic [3:0] OP_LEFT    = 4'd6;
    localparam logic [3:0] OP_DOWN    = 4'd7;
    localparam logic [3:0] OP_RIGHT   = 4'd8;

    // Cursor is the top-left of a 2x2 window, so it stops one short of the edge
    localparam logic [2:0] CUR_MIN = 3'd0;
    localparam logic [2:0] CUR_MAX = 3'd6;
    localparam logic [2:0] WIN_THR = 3'd4;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StExec,
        StOut,
        StDrain
    } state_e;

endpackage

// File: rtl/map_rd_addr_gen.sv
// Read address for result index k (4x4 window, r=k[3:2], c=k[1:0]).
module map_rd_addr_gen
    import map_pkg::*;
(
    input  logic [2:0]        win_x,
    input  logic [2:0]        win_y,
    input  logic [3:0]        k,
    output logic [ADDR_W-1:0] rd_addr
);

    logic [1:0] r;
    logic [1:0] c;

    assign r = k[3:2];
    assign c = k[1:0];

    // Window near the far edge falls back to a stride-2 sample of the whole map
    always_comb begin
        if (win_x >= WIN_THR || win_y >= WIN_THR) begin
            rd_addr = {r, 1'b0, c, 1'b0};
        end else begin
            rd_addr = {win_x + 3'd1 + {1'b0, r}, win_y + 3'd1 + {1'b0, c}};
        end
    end

endmodule

// File: rtl/map_op_sequencer.sv
// Load / execute / read-out sequencer for the 8x8 map-transform datapath.
// Optional macro MAP_SEQ_CLK_GATE_EN: gate the datapath clock enable on activity.
module map_op_sequencer
    import map_pkg::*;
#(
    parameter int unsigned CUR_INIT = 3,
    parameter int unsigned RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [3:0]        op,
    input  logic              cg_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              exec_valid,
    output logic [2:0]        exec_op,
    output logic [2:0]        win_x,
    output logic [2:0]        win_y,
    input  logic              exec_ready,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              out_valid,
    output logic              busy,
    output logic              dp_clk_en
);

    localparam logic [2:0] CUR_RST    = 3'(CUR_INIT);
    localparam logic [1:0] DRAIN_LAST = 2'(RD_LAT - 1);

    state_e            state_q, state_d;
    logic [5:0]        beat_q, beat_d;
    logic [3:0]        op_idx_q, op_idx_d;
    logic [3:0]        rd_k_q, rd_k_d;
    logic [1:0]        drain_q, drain_d;
    logic [2:0]        cur_x_q, cur_x_d;
    logic [2:0]        cur_y_q, cur_y_d;
    logic [3:0]        op_buf_q [OP_NUM];
    logic [RD_LAT-1:0] out_pipe_q;
    logic [3:0]        cur_op;
    logic              op_wr;
    logic              exec_done;
    logic [ADDR_W-1:0] gen_addr;

    assign cur_op    = op_buf_q[op_idx_q];
    assign wr_addr   = beat_q;
    assign win_x     = cur_x_q;
    assign win_y     = cur_y_q;
    assign busy      = (state_q != StIdle);
    assign op_wr     = wr_en && (beat_q < 6'(OP_NUM));
    assign out_valid = out_pipe_q[RD_LAT-1];
    assign rd_addr   = rd_en ? gen_addr : '0;

    map_rd_addr_gen u_rd_addr_gen (
        .win_x   (cur_x_q),
        .win_y   (cur_y_q),
        .k       (rd_k_q),
        .rd_addr (gen_addr)
    );

    // Next-state and command outputs
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        op_idx_d   = op_idx_q;
        rd_k_d     = rd_k_q;
        drain_d    = drain_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        wr_en      = 1'b0;
        exec_valid = 1'b0;
        exec_op    = 3'd0;
        exec_done  = 1'b0;
        rd_en      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    wr_en   = 1'b1;
                    beat_d  = beat_q + 6'd1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (beat_q == 6'(NUM_BEATS - 1)) begin
                        beat_d   = '0;
                        op_idx_d = '0;
                        cur_x_d  = CUR_RST;
                        cur_y_d  = CUR_RST;
                        state_d  = StExec;
                    end else begin
                        beat_d = beat_q + 6'd1;
                    end
                end
            end
            StExec: begin
                exec_done = 1'b1;
                case (cur_op)
                    OP_MID, OP_AVG, OP_ROT_CCW, OP_ROT_CW, OP_FLIP: begin
                        exec_valid = 1'b1;
                        exec_op    = cur_op[2:0];
                        exec_done  = exec_ready;
                    end
                    OP_UP:    if (cur_x_q != CUR_MIN) cur_x_d = cur_x_q - 3'd1;
                    OP_LEFT:  if (cur_y_q != CUR_MIN) cur_y_d = cur_y_q - 3'd1;
                    OP_DOWN:  if (cur_x_q != CUR_MAX) cur_x_d = cur_x_q + 3'd1;
                    OP_RIGHT: if (cur_y_q != CUR_MAX) cur_y_d = cur_y_q + 3'd1;
                    default: ;
                endcase
                if (exec_done) begin
                    if (op_idx_q == 4'(OP_NUM - 1)) begin
                        rd_k_d  = '0;
                        state_d = StOut;
                    end else begin
                        op_idx_d = op_idx_q + 4'd1;
                    end
                end
            end
            StOut: begin
                rd_en = 1'b1;
                if (rd_k_q == 4'(RD_NUM - 1)) begin
                    drain_d = '0;
                    state_d = StDrain;
                end else begin
                    rd_k_d = rd_k_q + 4'd1;
                end
            end
            StDrain: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = StIdle;
                    // Exit cycle behaves like IDLE so a waiting pattern loses no beat
                    if (in_valid) begin
                        wr_en   = 1'b1;
                        beat_d  = beat_q + 6'd1;
                        state_d = StLoad;
                    end
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            beat_q   <= '0;
            op_idx_q <= '0;
            rd_k_q   <= '0;
            drain_q  <= '0;
            cur_x_q  <= CUR_RST;
            cur_y_q  <= CUR_RST;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            op_idx_q <= op_idx_d;
            rd_k_q   <= rd_k_d;
            drain_q  <= drain_d;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
        end
    end

    // Op buffer captures the op field of the first OP_NUM beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OP_NUM; i++) op_buf_q[i] <= '0;
        end else if (op_wr) begin
            op_buf_q[beat_q[3:0]] <= op;
        end
    end

    // out_valid tracks rd_en through the datapath read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_pipe_q <= '0;
        end else begin
            out_pipe_q[0] <= rd_en;
            for (int i = 1; i < RD_LAT; i++) out_pipe_q[i] <= out_pipe_q[i-1];
        end
    end

`ifdef MAP_SEQ_CLK_GATE_EN
    assign dp_clk_en = ~cg_en | wr_en | exec_valid | rd_en | (|out_pipe_q);
`else
    logic dp_on_q;
    logic unused_cg_en;

    assign unused_cg_en = cg_en;
    assign dp_clk_en    = dp_on_q;

    // Enable is simply held high once out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dp_on_q <= 1'b0;
        else        dp_on_q <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_map_op_sequencer.sv
// Self-checking bench for map_op_sequencer with a queue-based reference model.
module tb_map_op_sequencer;

    localparam int RD_LAT   = 1;
    localparam int CUR_INIT = 3;

    logic       clk, rst_n, in_valid, cg_en, exec_ready;
    logic [3:0] op;
    logic       wr_en, exec_valid, rd_en, out_valid, busy, dp_clk_en;
    logic [5:0] wr_addr, rd_addr;
    logic [2:0] exec_op, win_x, win_y;

    map_op_sequencer #(.CUR_INIT(CUR_INIT), .RD_LAT(RD_LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .op         (op),
        .cg_en      (cg_en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .exec_valid (exec_valid),
        .exec_op    (exec_op),
        .win_x      (win_x),
        .win_y      (win_y),
        .exec_ready (exec_ready),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .out_valid  (out_valid),
        .busy       (busy),
        .dp_clk_en  (dp_clk_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [3:0] pat_ops [15];
    int obs_wr[$], obs_cmd[$], obs_rd[$], exp_cmd[$], exp_rd[$];
    int ov_cycles, ov_first, rd_first, ov_runs, cg_err, early_exec, stall_err, exec_cycles;
    int rd_win, exp_x, exp_y;
    bit timed_out, hit_rst;

    function automatic int qdiff(input int a[$], input int b[$]);
        int d;
        d = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
        for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] != b[i]) d++;
        return d;
    endfunction

    function automatic int qfirst(input int a[$]);
        return (a.size() > 0) ? a[0] : -1;
    endfunction

    // Reference: walk the op list, record commands (op*100+x*10+y) and read addresses
    task automatic build_model();
        int x, y, r, c;
        x = CUR_INIT;
        y = CUR_INIT;
        exp_cmd.delete();
        exp_rd.delete();
        for (int i = 0; i < 15; i++) begin
            case (int'(pat_ops[i]))
                0, 1, 2, 3, 4: exp_cmd.push_back(int'(pat_ops[i]) * 100 + x * 10 + y);
                5: if (x > 0) x--;
                6: if (y > 0) y--;
                7: if (x < 6) x++;
                8: if (y < 6) y++;
                default: ;
            endcase
        end
        exp_x = x;
        exp_y = y;
        for (int k = 0; k < 16; k++) begin
            r = k / 4;
            c = k % 4;
            if (x >= 4 || y >= 4) exp_rd.push_back(2 * r * 8 + 2 * c);
            else                  exp_rd.push_back((x + 1 + r) * 8 + (y + 1 + c));
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < 15; i++) pat_ops[i] = 4'($urandom_range(0, 15));
    endtask

    // Drive one pattern and collect observations; stops when busy falls or at read rst_at_k
    task automatic run_pattern(input int ready_delay, input int gap_at, input int gap_len,
                               input bit cg, input int rst_at_k);
        int beat, gap_done, stall;
        bit was_busy, prev_ov, load_done, fin, exp_dp;
        logic [2:0] p_op, p_x, p_y;
        logic [7:0] rd_hist;
        beat = 0; gap_done = 0; stall = 0;
        was_busy = 0; prev_ov = 0; fin = 0; rd_hist = '0;
        p_op = '0; p_x = '0; p_y = '0;
        obs_wr.delete(); obs_cmd.delete(); obs_rd.delete();
        ov_cycles = 0; ov_first = -1; rd_first = -1; ov_runs = 0; cg_err = 0;
        early_exec = 0; stall_err = 0; exec_cycles = 0; rd_win = -1;
        timed_out = 1; hit_rst = 0;
        for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
            @(negedge clk);
            load_done = (beat == 64);
            cg_en = cg;
            if (beat < 64 && beat == gap_at && gap_done < gap_len) begin
                in_valid = 1'b0;
                op = 4'($urandom);
                gap_done++;
            end else if (beat < 64) begin
                in_valid = 1'b1;
                op = (beat < 15) ? pat_ops[beat] : 4'($urandom);
                beat++;
            end else begin
                in_valid = 1'b0;
                op = 4'($urandom);
            end
            exec_ready = exec_valid ? (stall >= ready_delay) : 1'($urandom);
            #1;
            if (wr_en) obs_wr.push_back(int'(wr_addr));
            if (exec_valid) begin
                exec_cycles++;
                if (!load_done) early_exec++;
                if (stall > 0 && (exec_op !== p_op || win_x !== p_x || win_y !== p_y)) stall_err++;
                p_op = exec_op; p_x = win_x; p_y = win_y;
                if (exec_ready) begin
                    obs_cmd.push_back(int'(exec_op) * 100 + int'(win_x) * 10 + int'(win_y));
                    stall = 0;
                end else begin
                    stall++;
                end
            end
            if (rd_en) begin
                obs_rd.push_back(int'(rd_addr));
                if (rd_first < 0) begin
                    rd_first = cyc;
                    rd_win = int'(win_x) * 10 + int'(win_y);
                end
            end
            if (out_valid) begin
                ov_cycles++;
                if (ov_first < 0) ov_first = cyc;
                if (!prev_ov) ov_runs++;
            end
`ifdef MAP_SEQ_CLK_GATE_EN
            exp_dp = !cg || wr_en || exec_valid || rd_en || ((rd_hist & 8'((1 << RD_LAT) - 1)) != 0);
`else
            exp_dp = 1'b1;
`endif
            if (dp_clk_en !== exp_dp) cg_err++;
            rd_hist = {rd_hist[6:0], rd_en};
            prev_ov = out_valid;
            if (busy) was_busy = 1;
            if (rst_at_k >= 0 && rd_en && obs_rd.size() == rst_at_k + 1) begin
                hit_rst = 1; timed_out = 0; fin = 1;
            end else if (was_busy && !busy) begin
                timed_out = 0; fin = 1;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; op = '0; exec_ready = 1'b0; cg_en = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({wr_en, exec_valid, rd_en, out_valid, busy, dp_clk_en} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 000000",
                     {wr_en, exec_valid, rd_en, out_valid, busy, dp_clk_en});
        end
        total++;
        if ({wr_addr, rd_addr, exec_op} !== 15'd0) begin
            bad++;
            $display("FAIL reset_buses: got wr=%0d rd=%0d op=%0d want 0", wr_addr, rd_addr, exec_op);
        end
        total++;
        if (win_x !== 3'(CUR_INIT) || win_y !== 3'(CUR_INIT)) begin
            bad++;
            $display("FAIL reset_win: got (%0d,%0d) want (%0d,%0d)", win_x, win_y, CUR_INIT, CUR_INIT);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        total++;
`ifdef MAP_SEQ_CLK_GATE_EN
        if (dp_clk_en !== 1'b0) begin
            bad++;
            $display("FAIL idle_dp_clk_en: got %b want 0", dp_clk_en);
        end
`else
        if (dp_clk_en !== 1'b1) begin
            bad++;
            $display("FAIL idle_dp_clk_en: got %b want 1", dp_clk_en);
        end
`endif
    endtask

    task automatic test_move_right();
        for (int i = 0; i < 15; i++) pat_ops[i] = 4'd8;
        build_model();
        run_pattern(0, -1, 0, 1'b0, -1);
        total++;
        if (timed_out) begin bad++; $display("FAIL right_done: timed out, want busy to fall"); end
        total++;
        if (obs_cmd.size() != 0) begin
            bad++; $display("FAIL right_no_exec: got %0d commands want 0", obs_cmd.size());
        end
        total++;
        if (rd_win != exp_x * 10 + exp_y) begin
            bad++; $display("FAIL right_cursor: got %0d want %0d", rd_win, exp_x * 10 + exp_y);
        end
        total++;
        if (qdiff(obs_rd, exp_rd) != 0) begin
            bad++;
            $display("FAIL right_rd: got n=%0d first=%0d want n=%0d first=%0d",
                     obs_rd.size(), qfirst(obs_rd), exp_rd.size(), qfirst(exp_rd));
        end
        total++;
        if (ov_cycles != 16 || ov_runs != 1) begin
            bad++; $display("FAIL right_out_valid: got %0d cycles %0d runs want 16/1", ov_cycles, ov_runs);
        end
        total++;
        if (ov_first - rd_first != RD_LAT) begin
            bad++; $display("FAIL right_out_lat: got %0d want %0d", ov_first - rd_first, RD_LAT);
        end
    endtask

    task automatic test_flip();
        for (int i = 0; i < 15; i++) pat_ops[i] = 4'd4;
        build_model();
        run_pattern(0, -1, 0, 1'b0, -1);
        total++;
        if (timed_out) begin bad++; $display("FAIL flip_done: timed out, want busy to fall"); end
        total++;
        if (qdiff(obs_cmd, exp_cmd) != 0) begin
            bad++;
            $display("FAIL flip_cmds: got n=%0d first=%0d want n=%0d first=%0d",
                     obs_cmd.size(), qfirst(obs_cmd), exp_cmd.size(), qfirst(exp_cmd));
        end
        total++;
        if (exec_cycles != 15) begin
            bad++; $display("FAIL flip_pulses: got %0d exec_valid cycles want 15", exec_cycles);
        end
        total++;
        if (qdiff(obs_rd, exp_rd) != 0) begin
            bad++;
            $display("FAIL flip_rd: got n=%0d first=%0d want n=%0d first=%0d",
                     obs_rd.size(), qfirst(obs_rd), exp_rd.size(), qfirst(exp_rd));
        end
    endtask

    task automatic test_moves_stall();
        int v;
        for (int i = 0; i < 4; i++) pat_ops[i] = 4'd5;
        for (int i = 4; i < 8; i++) pat_ops[i] = 4'd6;
        pat_ops[8] = 4'd0;
        for (int i = 9; i < 15; i++) begin
            v = $urandom_range(0, 11);
            pat_ops[i] = 4'((v < 5) ? v : v + 4);
        end
        build_model();
        run_pattern(3, -1, 0, 1'b0, -1);
        total++;
        if (timed_out) begin bad++; $display("FAIL stall_done: timed out, want busy to fall"); end
        total++;
        if (qfirst(obs_cmd) != 0) begin
            bad++; $display("FAIL stall_first_cmd: got %0d want 0 (op0 at 0,0)", qfirst(obs_cmd));
        end
        total++;
        if (qdiff(obs_cmd, exp_cmd) != 0) begin
            bad++;
            $display("FAIL stall_cmds: got n=%0d want n=%0d", obs_cmd.size(), exp_cmd.size());
        end
        total++;
        if (stall_err != 0 || exec_cycles != 4 * exp_cmd.size()) begin
            bad++;
            $display("FAIL stall_hold: got %0d unstable, %0d cycles want 0, %0d",
                     stall_err, exec_cycles, 4 * exp_cmd.size());
        end
        total++;
        if (qfirst(obs_rd) != 9 || qdiff(obs_rd, exp_rd) != 0) begin
            bad++;
            $display("FAIL stall_rd: got n=%0d first=%0d want n=16 first=9",
                     obs_rd.size(), qfirst(obs_rd));
        end
    endtask

    task automatic test_load_gap();
        int seq[$];
        for (int i = 0; i < 64; i++) seq.push_back(i);
        for (int i = 0; i < 15; i++) pat_ops[i] = 4'($urandom_range(0, 4));
        build_model();
        run_pattern(1, 30, 5, 1'b0, -1);
        total++;
        if (timed_out) begin bad++; $display("FAIL gap_done: timed out, want busy to fall"); end
        total++;
        if (qdiff(obs_wr, seq) != 0) begin
            bad++;
            $display("FAIL gap_wr_seq: got n=%0d with %0d diffs want 0..63", obs_wr.size(),
                     qdiff(obs_wr, seq));
        end
        total++;
        if (early_exec != 0) begin
            bad++; $display("FAIL gap_early_exec: got %0d cycles want 0", early_exec);
        end
        total++;
        if (qdiff(obs_cmd, exp_cmd) != 0) begin
            bad++;
            $display("FAIL gap_cmds: got n=%0d want n=%0d", obs_cmd.size(), exp_cmd.size());
        end
    endtask

    task automatic test_reset_mid_out();
        rand_ops();
        build_model();
        run_pattern(0, -1, 0, 1'b0, 7);
        total++;
        if (!hit_rst) begin bad++; $display("FAIL rst_reach_k7: got no k=7 read want one"); end
        rst_n = 1'b0;
        #1;
        total++;
        if ({rd_en, out_valid, busy, exec_valid} !== 4'b0) begin
            bad++;
            $display("FAIL rst_immediate: got rd/ov/busy/ev=%b want 0000",
                     {rd_en, out_valid, busy, exec_valid});
        end
        @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL rst_out_valid_held: got %b want 0", out_valid);
        end
        rst_n = 1'b1;
        rand_ops();
        build_model();
        run_pattern(2, -1, 0, 1'b0, -1);
        total++;
        if (timed_out || qdiff(obs_cmd, exp_cmd) != 0 || qdiff(obs_rd, exp_rd) != 0
            || ov_cycles != 16) begin
            bad++;
            $display("FAIL rst_clean_run: got cmds=%0d rds=%0d ov=%0d want %0d/16/16",
                     obs_cmd.size(), obs_rd.size(), ov_cycles, exp_cmd.size());
        end
    endtask

    task automatic test_random();
        for (int p = 0; p < 6; p++) begin
            rand_ops();
            build_model();
            run_pattern($urandom_range(0, 4), $urandom_range(1, 63), $urandom_range(0, 4),
                        1'($urandom), -1);
            total++;
            if (timed_out || qdiff(obs_cmd, exp_cmd) != 0) begin
                bad++;
                $display("FAIL rand%0d_cmds: got n=%0d first=%0d want n=%0d first=%0d", p,
                         obs_cmd.size(), qfirst(obs_cmd), exp_cmd.size(), qfirst(exp_cmd));
            end
            total++;
            if (qdiff(obs_rd, exp_rd) != 0) begin
                bad++;
                $display("FAIL rand%0d_rd: got n=%0d first=%0d want n=%0d first=%0d", p,
                         obs_rd.size(), qfirst(obs_rd), exp_rd.size(), qfirst(exp_rd));
            end
            total++;
            if (ov_cycles != 16 || ov_runs != 1 || ov_first - rd_first != RD_LAT) begin
                bad++;
                $display("FAIL rand%0d_out_valid: got %0d cycles %0d runs lat %0d want 16/1/%0d",
                         p, ov_cycles, ov_runs, ov_first - rd_first, RD_LAT);
            end
        end
    endtask

    task automatic test_clk_gate();
        for (int g = 0; g < 2; g++) begin
            rand_ops();
            pat_ops[0] = 4'd5;
            pat_ops[1] = 4'd2;
            build_model();
            run_pattern(2, 20, 3, (g == 0), -1);
            total++;
            if (timed_out || cg_err != 0) begin
                bad++;
                $display("FAIL clk_gate_cg%0d: got %0d bad dp_clk_en cycles want 0", (g == 0), cg_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_move_right();
        test_flip();
        test_moves_stall();
        test_load_gap();
        test_reset_mid_out();
        test_random();
        test_clk_gate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/map_op_sequencer.md
Name: map_op_sequencer

Overview:
Controller for the 8x8 signed 7-bit map-transform datapath. Loads 64 map words and 15 op codes, then walks the 2x2 cursor window. Dispatches each transform op (midpoint/average/rotate/flip) to the datapath over a valid/ready handshake and resolves move ops internally. Finally issues 16 read addresses for the 4x4 result window and frames out_valid. It sits between the pattern-facing input port and the map register file/ALU.

Parameters:
MAP_DIM, 8, map side length; addresses are 6-bit {row[2:0],col[2:0]}
OP_NUM, 15, op codes captured per pattern
CUR_INIT, 3, reset/start value of cursor x and y
RD_LAT, 1, cycles from rd_en to datapath read data valid (1..3)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat qualifier
op  in  4  op code; sampled on the first OP_NUM beats only
cg_en  in  1  clock-gating permission
wr_en  out  1  store in_data at wr_addr this cycle
wr_addr  out  6  load address, raster order
exec_valid  out  1  transform command valid
exec_op  out  3  0 midpoint, 1 average, 2 inv-clock rotate, 3 clock rotate, 4 flip
win_x  out  3  window top-left row
win_y  out  3  window top-left col
exec_ready  in  1  datapath accepts the command
rd_en  out  1  read request
rd_addr  out  6  read address
out_valid  out  1  result data valid (rd_en delayed RD_LAT)
busy  out  1  high in any state except IDLE
dp_clk_en  out  1  datapath clock enable (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; win_x=win_y=CUR_INIT; beat/op/read counters 0; op buffer cleared. A reset mid-operation aborts immediately, with no partial output framing.
- States: IDLE, LOAD, EXEC, OUT, DRAIN.
- IDLE: in_valid=1 moves to LOAD. That beat is beat 0: wr_en=1, wr_addr=0 in the same cycle, combinational from in_valid and the counter.
- LOAD: each in_valid beat asserts wr_en with wr_addr=beat index. Beats 0..14 also store op into an op buffer (4-bit x15).
  - A gap (in_valid=0) stalls the count; it is not an error.
  - After beat 63, go to EXEC with op index 0 and cursor=(CUR_INIT,CUR_INIT).
- EXEC, one op per step:
  - Move ops are consumed in one cycle with no exec_valid. 5 Up: x-1 unless x==0. 6 Left: y-1 unless y==0. 7 Down: x+1 unless x==6. 8 Right: y+1 unless y==6.
  - Ops 0-4: assert exec_valid with exec_op, win_x, win_y. These are held stable until exec_ready=1; the command completes on the cycle with exec_valid&exec_ready. exec_ready while exec_valid=0 is ignored.
  - Ops 9-15 are treated as no-op, one cycle.
  - After op 14 completes, go to OUT.
- OUT: 16 consecutive cycles with rd_en=1, read index k=0..15, r=k[3:2], c=k[1:0].
  - If win_x>=4 or win_y>=4: rd_addr={2r,2c}.
  - Else: rd_addr={win_x+1+r, win_y+1+c}.
  - After k=15, go to DRAIN.
- DRAIN: wait RD_LAT cycles, then IDLE.
- out_valid is rd_en through an RD_LAT-deep shift register: exactly 16 contiguous high cycles per pattern.
- in_valid is ignored outside IDLE/LOAD. in_valid in the same cycle DRAIN exits to IDLE starts a new LOAD.

Optional Feature:
MAP_SEQ_CLK_GATE_EN. When defined, dp_clk_en = ~cg_en | wr_en | (exec_valid) | rd_en | (out_valid pipeline non-empty), so the datapath clock idles during IDLE, move ops and LOAD gaps. When undefined, dp_clk_en is constant 1 out of reset and cg_en is unused.

Decomposition:
- Shared package map_pkg:
  - op code constants OP_MID=0 .. OP_RIGHT=8
  - state enum
  - MAP_DIM, ADDR_W=6
  - cursor bound constants 0/6
  - window threshold 4
- One sub-module, map_rd_addr_gen: combinational function of (win_x, win_y, k) producing rd_addr; verified standalone.

Test Plan:
- 64 contiguous beats, ops all 8 (Right) -> no exec_valid; cursor saturates at y=6; rd_addr = 0,2,4,6,16,18,...,54; out_valid high exactly 16 cycles, RD_LAT after first rd_en.
- Ops = 15x 4 (Flip), exec_ready tied 1 -> 15 single-cycle exec_valid pulses, win=(3,3); reads 36,37,38,39,44,...,63.
- Ops 5,5,5,5,6,6,6,6,0,... with exec_ready asserted 3 cycles late -> win_x=0, win_y=0 at exec; exec_op/win stable through the stall; reads start at addr 9.
- in_valid dropped for 5 cycles at beat 30 -> wr_addr resumes at 30; no EXEC entry before 64 beats.
- rst_n pulsed during OUT at k=7 -> out_valid/rd_en low immediately; next pattern runs clean from IDLE.
- With MAP_SEQ_CLK_GATE_EN and cg_en=1 -> dp_clk_en=0 in IDLE and on move-op cycles, 1 on every wr_en/exec_valid/rd_en/out_valid cycle; with cg_en=0 -> dp_clk_en=1 continuously.
